// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and defaults for the iCE40 pixel-clock PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_seq_state_e;

  localparam int unsigned RST_CYCLES_DEF    = 12;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 1200;
  localparam int unsigned STABLE_CYCLES_DEF = 120;
  localparam int unsigned MAX_RETRIES_DEF   = 3;

  localparam int unsigned RETRY_W = 4;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL control/status bundle: master = sequencer, slave = PLL wrapper / downstream consumers.
interface pll_lock_sequencer_if;
  logic                             pll_lock;
  logic                             pll_resetb;
  logic                             sys_rst_n;
  logic                             ready;
  logic                             lock_lost;
  logic [pll_seq_pkg::RETRY_W-1:0]  retry_cnt;
  logic                             fail;

  modport master (
    input  pll_lock,
    output pll_resetb, sys_rst_n, ready, lock_lost, retry_cnt, fail
  );

  modport slave (
    output pll_lock,
    input  pll_resetb, sys_rst_n, ready, lock_lost, retry_cnt, fail
  );
endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// 1-bit two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer with stable-lock qualification and lock-loss supervision.
// Optional retry limit and FAIL state: define PLL_SEQ_RETRY_LIMIT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRIES   = MAX_RETRIES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);
  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRIES < 1) begin : g_param_err
    $error("pll_lock_sequencer: cycle parameters and MAX_RETRIES must be >= 1");
  end

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (bus.pll_lock),
    .q     (lock_s)
  );

  pll_seq_state_e     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic               lock_lost_q, lock_lost_d;
  logic               pll_resetb_q, pll_resetb_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               expired;

  always_comb begin
    state_d     = state_q;
    expired     = (cnt_q == '0);
    cnt_d       = expired ? '0 : cnt_q - CNT_W'(1);
    retry_cnt_d = retry_cnt_q;
    lock_lost_d = lock_lost_q;

    case (state_q)
      PLL_RST: begin
        if (expired) begin
          state_d = WAIT_LOCK;
          cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
        end
      end
      WAIT_LOCK: begin
        // Lock is checked before the timeout so a same-cycle tie is not a retry.
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = CNT_W'(STABLE_CYCLES - 1);
        end else if (expired) begin
          if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + RETRY_W'(1);
          state_d = PLL_RST;
          cnt_d   = CNT_W'(RST_CYCLES - 1);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          if (32'(retry_cnt_d) == MAX_RETRIES) state_d = FAIL;
`endif
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
        end else if (expired) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d     = PLL_RST;
          cnt_d       = CNT_W'(RST_CYCLES - 1);
          lock_lost_d = 1'b1;
        end
      end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      FAIL: begin
        state_d = FAIL;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = PLL_RST;
        cnt_d   = CNT_W'(RST_CYCLES - 1);
      end
    endcase

    pll_resetb_d = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
    sys_rst_n_d  = (state_d == RUN);
    ready_d      = (state_d == RUN);
    fail_d       = (state_d == FAIL);
  end

  // Reset count is one longer than a normal load: release counts as the PLL_RST entry edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PLL_RST;
      cnt_q        <= CNT_W'(RST_CYCLES);
      retry_cnt_q  <= '0;
      lock_lost_q  <= 1'b0;
      pll_resetb_q <= 1'b0;
      sys_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      lock_lost_q  <= lock_lost_d;
      pll_resetb_q <= pll_resetb_d;
      sys_rst_n_q  <= sys_rst_n_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.pll_resetb = pll_resetb_q;
  assign bus.sys_rst_n  = sys_rst_n_q;
  assign bus.ready      = ready_q;
  assign bus.lock_lost  = lock_lost_q;
  assign bus.retry_cnt  = retry_cnt_q;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  assign bus.fail       = fail_q;
`else
  assign bus.fail       = 1'b0;
`endif
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed, table-driven bench for pll_lock_sequencer (RST=4, TIMEOUT=20, STABLE=8, RETRIES=3).
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned bad    = 0;
  int unsigned edge_n = 0;

  typedef struct {
    int unsigned at;
    logic        drive;
    logic        rb;
    logic        sys;
    logic        rdy;
    logic        lost;
    logic [3:0]  rc;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic chk(input string tag, input logic rb, input logic sys, input logic rdy,
                     input logic lost, input logic [3:0] rc, input logic fl);
    cmp({tag, ".pll_resetb"}, {3'b0, bus.pll_resetb}, {3'b0, rb});
    cmp({tag, ".sys_rst_n"},  {3'b0, bus.sys_rst_n},  {3'b0, sys});
    cmp({tag, ".ready"},      {3'b0, bus.ready},      {3'b0, rdy});
    cmp({tag, ".lock_lost"},  {3'b0, bus.lock_lost},  {3'b0, lost});
    cmp({tag, ".retry_cnt"},  bus.retry_cnt,          rc);
    cmp({tag, ".fail"},       {3'b0, bus.fail},       {3'b0, fl});
  endtask

  // Advance to 1 time unit after the given edge (counted from reset release).
  task automatic goto(input int unsigned t);
    while (edge_n < t) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("async_rst", 0, 0, 0, 0, 4'd0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            at  drv rb sys rdy lost rc
    tbl[0]  = '{  4, 0, 0, 0, 0, 0, 4'd0};
    tbl[1]  = '{  5, 0, 1, 0, 0, 0, 4'd0};
    tbl[2]  = '{ 15, 1, 1, 0, 0, 0, 4'd0};
    tbl[3]  = '{ 25, 1, 1, 0, 0, 0, 4'd0};
    tbl[4]  = '{ 26, 0, 1, 1, 1, 0, 4'd0};
    tbl[5]  = '{ 28, 0, 1, 1, 1, 0, 4'd0};
    tbl[6]  = '{ 29, 0, 0, 0, 0, 1, 4'd0};
    tbl[7]  = '{ 32, 0, 0, 0, 0, 1, 4'd0};
    tbl[8]  = '{ 33, 1, 1, 0, 0, 1, 4'd0};
    tbl[9]  = '{ 43, 1, 1, 0, 0, 1, 4'd0};
    tbl[10] = '{ 44, 0, 1, 1, 1, 1, 4'd0};
    tbl[11] = '{ 46, 0, 1, 1, 1, 1, 4'd0};
    tbl[12] = '{ 47, 0, 0, 0, 0, 1, 4'd0};
    tbl[13] = '{ 50, 0, 0, 0, 0, 1, 4'd0};
    tbl[14] = '{ 51, 1, 1, 0, 0, 1, 4'd0};
    tbl[15] = '{ 56, 0, 1, 0, 0, 1, 4'd0};
    tbl[16] = '{ 57, 1, 1, 0, 0, 1, 4'd0};
    tbl[17] = '{ 59, 1, 1, 0, 0, 1, 4'd0};
    tbl[18] = '{ 62, 1, 1, 0, 0, 1, 4'd0};
    tbl[19] = '{ 67, 1, 1, 0, 0, 1, 4'd0};
    tbl[20] = '{ 68, 0, 1, 1, 1, 1, 4'd0};

    bus.pll_lock = 1'b0;
    #3;
    do_reset();

    // Clean start, loss in RUN with relock, second loss, glitch during STABLE.
    for (int i = 0; i < NV; i++) begin
      goto(tbl[i].at);
      chk($sformatf("vec%0d", i), tbl[i].rb, tbl[i].sys, tbl[i].rdy, tbl[i].lost, tbl[i].rc, 1'b0);
      bus.pll_lock = tbl[i].drive;
    end

    // Mid-operation reset at stable count 5.
    goto(71);  chk("loss3", 0, 0, 0, 1, 4'd0, 0);
    goto(75);  chk("relock3_wait", 1, 0, 0, 1, 4'd0, 0);
    bus.pll_lock = 1'b1;
    goto(83);  chk("stable5", 1, 0, 0, 1, 4'd0, 0);
    do_reset();
    goto(4);   chk("rerun_rst", 0, 0, 0, 0, 4'd0, 0);
    goto(5);   chk("rerun_wait", 1, 0, 0, 0, 4'd0, 0);
    goto(13);  chk("rerun_stable", 1, 0, 0, 0, 4'd0, 0);
    goto(14);  chk("rerun_run", 1, 1, 1, 0, 4'd0, 0);

    // Timeout/lock tie: lock_s rises on the cycle the timeout expires.
    bus.pll_lock = 1'b0;
    goto(17);  chk("tie_loss", 0, 0, 0, 1, 4'd0, 0);
    goto(21);  chk("tie_wait", 1, 0, 0, 1, 4'd0, 0);
    goto(38);
    bus.pll_lock = 1'b1;
    goto(40);  chk("tie_pre", 1, 0, 0, 1, 4'd0, 0);
    goto(41);  chk("tie_edge", 1, 0, 0, 1, 4'd0, 0);
    goto(48);  chk("tie_stable", 1, 0, 0, 1, 4'd0, 0);
    goto(49);  chk("tie_run", 1, 1, 1, 1, 4'd0, 0);

    // No lock at all: 4 low / 20 high retry pulses.
    bus.pll_lock = 1'b0;
    do_reset();
    goto(24);  chk("nolock_w1", 1, 0, 0, 0, 4'd0, 0);
    goto(25);  chk("nolock_to1", 0, 0, 0, 0, 4'd1, 0);
    goto(28);  chk("nolock_r1", 0, 0, 0, 0, 4'd1, 0);
    goto(29);  chk("nolock_w2", 1, 0, 0, 0, 4'd1, 0);
    goto(48);  chk("nolock_w2e", 1, 0, 0, 0, 4'd1, 0);
    goto(49);  chk("nolock_to2", 0, 0, 0, 0, 4'd2, 0);
    goto(53);  chk("nolock_w3", 1, 0, 0, 0, 4'd2, 0);
    goto(72);  chk("nolock_w3e", 1, 0, 0, 0, 4'd2, 0);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    goto(73);  chk("nolock_fail", 0, 0, 0, 0, 4'd3, 1);
    goto(120); chk("nolock_fail_hold", 0, 0, 0, 0, 4'd3, 1);
`else
    goto(73);  chk("nolock_to3", 0, 0, 0, 0, 4'd3, 0);
    goto(77);  chk("nolock_w4", 1, 0, 0, 0, 4'd3, 0);
    goto(360); chk("nolock_w15e", 1, 0, 0, 0, 4'd14, 0);
    goto(361); chk("nolock_to15", 0, 0, 0, 0, 4'd15, 0);
    goto(384); chk("nolock_w16e", 1, 0, 0, 0, 4'd15, 0);
    goto(385); chk("nolock_sat", 0, 0, 0, 0, 4'd15, 0);
    goto(389); chk("nolock_w17", 1, 0, 0, 0, 4'd15, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
